// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronises rs232_rx, validates the start bit,
// deserialises LSB-first data on clk_bps pulses and checks the stop bit.
module uart_rx_frame #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rs232_rx,
  input  logic                 clk_bps,
  output logic                 bps_start,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_int,
  output logic                 frame_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;

  localparam logic [3:0] LAST = 4'(DATA_BITS - 1);

  logic rx0_q, rx1_q, rx2_q;
  logic neg_edge;

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic rx_int_q, rx_int_d;
  logic bps_start_q, bps_start_d;
  logic frame_err_q, frame_err_d;

  assign neg_edge = rx2_q & ~rx1_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_int_d    = rx_int_q;
    bps_start_d = bps_start_q;
    frame_err_d = frame_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (neg_edge) begin
          bps_start_d = 1'b1;
          state_d     = S_START;
        end
      end
      S_START: begin
        if (clk_bps) begin
          if (!rx1_q) begin
            rx_int_d = 1'b1;
            cnt_d    = 4'd0;
            state_d  = S_DATA;
          end else begin
            // glitch: drop the request without ever raising rx_int
            bps_start_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (clk_bps) begin
          shift_d = {rx1_q, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == LAST) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (clk_bps) begin
          rx_data_d   = shift_q;
          rx_int_d    = 1'b0;
          bps_start_d = 1'b0;
          frame_err_d = ~rx1_q;
          state_d     = rx1_q ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        // a held-low line (break) must not retrigger frames
        if (rx1_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx0_q       <= 1'b1;
      rx1_q       <= 1'b1;
      rx2_q       <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_int_q    <= 1'b0;
      bps_start_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx0_q       <= rs232_rx;
      rx1_q       <= rx0_q;
      rx2_q       <= rx1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_int_q    <= rx_int_d;
      bps_start_q <= bps_start_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bps_start = bps_start_q;
  assign rx_data   = rx_data_q;
  assign rx_int    = rx_int_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame with a simple baud model
// (16 clocks per bit, first pulse half a bit after bps_start).
module tb_uart_rx_frame;

  localparam int BIT  = 16;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rs232_rx = 1'b1;
  logic       clk_bps = 1'b0;
  logic       bps_start;
  logic [7:0] rx_data;
  logic       rx_int;
  logic       frame_err;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int bcnt = 0;
  int bps_cyc = 0;
  int fall_cyc = 0;
  int rise_cyc = 0;
  int line_cyc = 0;
  int n_falls = 0;
  int n_rises = 0;
  int n_bps = 0;
  logic prev_int = 1'b0;
  logic prev_bps = 1'b0;
  int base_f, base_r, base_b;

  uart_rx_frame #(.DATA_BITS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rs232_rx  (rs232_rx),
    .clk_bps   (clk_bps),
    .bps_start (bps_start),
    .rx_data   (rx_data),
    .rx_int    (rx_int),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // baud model
  always @(posedge clk) begin
    if (!bps_start) begin
      bcnt    <= 0;
      clk_bps <= 1'b0;
    end else begin
      bcnt    <= (bcnt == BIT - 1) ? 0 : bcnt + 1;
      clk_bps <= (bcnt == HALF - 1);
    end
  end

  always @(negedge clk) begin
    if (clk_bps) bps_cyc = cyc;
    if (prev_int && !rx_int) begin
      fall_cyc = cyc;
      n_falls++;
    end
    if (!prev_int && rx_int) n_rises++;
    if (!prev_bps && bps_start) begin
      rise_cyc = cyc;
      n_bps++;
    end
    prev_int = rx_int;
    prev_bps = bps_start;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called on a falling clock edge; returns on one
  task automatic send(input logic [7:0] b, input logic stop);
    rs232_rx = 1'b0;
    line_cyc = cyc;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rs232_rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rs232_rx = stop;
    repeat (BIT) @(negedge clk);
  endtask

  task automatic snap();
    base_f = n_falls;
    base_r = n_rises;
    base_b = n_bps;
  endtask

  initial begin
    #2;
    check("rst_bps", 32'(bps_start), 0);
    check("rst_int", 32'(rx_int), 0);
    check("rst_data", 32'(rx_data), 0);
    check("rst_ferr", 32'(frame_err), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // nominal 0xA5
    snap();
    send(8'hA5, 1'b1);
    check("a5_lat", 32'(rise_cyc - line_cyc), 3);
    check("a5_data", 32'(rx_data), 32'hA5);
    check("a5_ferr", 32'(frame_err), 0);
    check("a5_rise", 32'(n_rises - base_r), 1);
    check("a5_fall", 32'(n_falls - base_f), 1);
    check("a5_fdly", 32'(fall_cyc - bps_cyc), 1);
    check("a5_bps", 32'(bps_start), 0);
    repeat (4) @(negedge clk);

    // glitch
    snap();
    rs232_rx = 1'b0;
    repeat (4) @(negedge clk);
    rs232_rx = 1'b1;
    repeat (3 * BIT) @(negedge clk);
    check("gl_req", 32'(n_bps - base_b), 1);
    check("gl_bps", 32'(bps_start), 0);
    check("gl_rise", 32'(n_rises - base_r), 0);
    check("gl_data", 32'(rx_data), 32'hA5);

    // framing error then break
    snap();
    send(8'h3C, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    check("fe_data", 32'(rx_data), 32'h3C);
    check("fe_ferr", 32'(frame_err), 1);
    check("fe_fall", 32'(n_falls - base_f), 1);
    check("fe_nonew", 32'(n_bps - base_b), 1);
    check("fe_bps", 32'(bps_start), 0);
    rs232_rx = 1'b1;
    repeat (5) @(negedge clk);
    send(8'h55, 1'b1);
    check("fe55_data", 32'(rx_data), 32'h55);
    check("fe55_ferr", 32'(frame_err), 0);
    repeat (4) @(negedge clk);

    // back-to-back
    snap();
    send(8'h00, 1'b1);
    check("bb0_data", 32'(rx_data), 32'h00);
    check("bb0_ferr", 32'(frame_err), 0);
    send(8'hFF, 1'b1);
    check("bb1_data", 32'(rx_data), 32'hFF);
    check("bb1_ferr", 32'(frame_err), 0);
    check("bb_falls", 32'(n_falls - base_f), 2);
    repeat (4) @(negedge clk);

    // reset during data bit 4 of 0x81
    rs232_rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rs232_rx = (i == 0) ? 1'b1 : 1'b0;
      repeat (BIT) @(negedge clk);
    end
    rs232_rx = 1'b0;
    repeat (HALF) @(negedge clk);
    check("mr_pre_int", 32'(rx_int), 1);
    #1 rst_n = 1'b0;
    #1;
    check("mr_bps", 32'(bps_start), 0);
    check("mr_int", 32'(rx_int), 0);
    check("mr_data", 32'(rx_data), 0);
    check("mr_ferr", 32'(frame_err), 0);
    rs232_rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mr_idle", 32'(bps_start), 0);
    send(8'h81, 1'b1);
    check("mr81_data", 32'(rx_data), 32'h81);
    check("mr81_ferr", 32'(frame_err), 0);
    repeat (4) @(negedge clk);

    // 0x5A
    snap();
    send(8'h5A, 1'b1);
    check("e5a_data", 32'(rx_data), 32'h5A);
    check("e5a_fall", 32'(n_falls - base_f), 1);
    check("e5a_fdly", 32'(fall_cyc - bps_cyc), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
